pulse_event_arbiter: RTL

Multi-channel front end that debounces NUM_CH noisy pulse inputs and serialises their clean rising-edge events onto one valid/ready event port tagged with channel ID. Round-robin arbitration shares the single downstream consumer among all channels. Sits between raw pad/sensor inputs and the event-processing logic, in the same domain as the pulse_cleaner datapath.

---
 rtl/pulse_pkg.sv | 13 +
 rtl/pulse_event_arbiter_if.sv | 20 ++
 rtl/rr_pick.sv | 32 +++
 rtl/pulse_event_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared constants and helpers for the pulse event arbiter: drop counter width,
// its saturation value, and channel-ID width derivation.
package pulse_pkg;

    localparam int unsigned DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_SAT = '1;

    // Channel-ID width that stays at least one bit wide for tiny channel counts.
    function automatic int unsigned ch_idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulse_event_arbiter_if.sv
// Valid/ready event port carrying the channel ID of each clean rising edge.
interface pulse_event_arbiter_if #(
    parameter int unsigned CH_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;

    modport master (
        output evt_valid,
        output evt_ch,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        output evt_ready
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of pending searching
// upward from last_grant+1 with wrap-around.
module rr_pick
    import pulse_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CH_W-1:0]   last_grant,
    output logic              grant_valid,
    output logic [CH_W-1:0]   grant_idx
);

    always_comb begin
        int unsigned     idx;
        logic [CH_W-1:0] idx_v;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_v       = '0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            idx   = (int'(last_grant) + off) % NUM_CH;
            idx_v = CH_W'(idx);
            if (!grant_valid && pending[idx_v]) begin
                grant_valid = 1'b1;
                grant_idx   = idx_v;
            end
        end
    end

endmodule

// File: rtl/pulse_event_arbiter.sv
// Debounces NUM_CH noisy inputs and serialises their rising edges onto one
// valid/ready port with round-robin arbitration. PULSE_ARB_SYNC_EN adds a
// two-flop synchroniser per channel ahead of the debouncer.
module pulse_event_arbiter
    import pulse_pkg::*;
#(
    parameter int unsigned NUM_CH           = 4,
    parameter int unsigned DEBOUNCE_CNT_MAX = 4,
    parameter int unsigned CH_W             = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     noisy_in,
    pulse_event_arbiter_if.master evt,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT_MAX - 1);

    logic [NUM_CH-1:0] sampled;

`ifdef PULSE_ARB_SYNC_EN
    logic [NUM_CH-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= noisy_in;
            sync2_q <= sync1_q;
        end
    end
    assign sampled = sync2_q;
`else
    assign sampled = noisy_in;
`endif

    logic [NUM_CH-1:0]     stable_q, stable_d, rise;
    logic [CNT_W-1:0]      cnt_q [NUM_CH];
    logic [CNT_W-1:0]      cnt_d [NUM_CH];
    logic [NUM_CH-1:0]     pending_q, pending_d;
    logic [CH_W-1:0]       last_grant_q, evt_ch_q;
    logic                  evt_valid_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  slot_free, pick_valid, grant;
    logic [CH_W-1:0]       pick_idx;

    always_comb begin
        stable_d = stable_q;
        rise     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
            if (sampled[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = ~stable_q[i];
                    rise[i]     = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .pending     (pending_q),
        .last_grant  (last_grant_q),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    assign slot_free = !evt_valid_q || evt.evt_ready;
    assign grant     = slot_free && pick_valid;

    // A rise on the channel being granted this edge is a fresh event, not a drop.
    always_comb begin
        int unsigned drops;
        int unsigned drop_sum;
        logic        clr;
        drops     = 0;
        drop_sum  = 0;
        clr       = 1'b0;
        pending_d = pending_q;
        for (int i = 0; i < NUM_CH; i++) begin
            clr = grant && (pick_idx == CH_W'(i));
            if (clr) pending_d[i] = 1'b0;
            if (rise[i]) begin
                if (pending_q[i] && !clr) drops++;
                pending_d[i] = 1'b1;
            end
        end
        drop_sum   = int'(drop_cnt_q) + drops;
        drop_cnt_d = (drop_sum > int'(DROP_CNT_SAT)) ? DROP_CNT_SAT : DROP_CNT_W'(drop_sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q     <= '0;
            pending_q    <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            evt_ch_q     <= '0;
            evt_valid_q  <= 1'b0;
            drop_cnt_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            stable_q   <= stable_d;
            pending_q  <= pending_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
            if (grant) begin
                evt_valid_q  <= 1'b1;
                evt_ch_q     <= pick_idx;
                last_grant_q <= pick_idx;
            end else if (slot_free) begin
                evt_valid_q <= 1'b0;
            end
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_ch    = evt_ch_q;
    assign drop_cnt      = drop_cnt_q;

endmodule
